fan_tach_counter: RTL and testbench
===================================

# fan_tach_counter

Fan speed measurement stage feeding the actual-value input of the fan controller's PID loop. Synchronises and glitch-filters the open-collector tachometer signal, counts filtered rising edges over a fixed gate window derived from the system clock, and publishes one saturated 8-bit speed sample per window with a one-cycle valid strobe. Also flags a stalled fan after a configurable number of consecutive zero-count windows.

## Interface
- GATE_DIV, 17'd99_999, gate window length minus one, in clk cycles (window = GATE_DIV+1 cycles)
- DEBOUNCE_LEN, 3, consecutive cycles a synchronised level change must persist before it is accepted (>=1)
- STALL_WINDOWS, 3, consecutive zero-count windows before stall is flagged (1..15)

- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- ena  input  1  block enable; low = idle/clear window state
- tach_in  input  1  raw fan tachometer, asynchronous to clk
- speed_o  output  8  edges counted in last complete window, saturated at 255
- speed_valid_o  output  1  one-cycle strobe, speed_o updated this cycle
- speed_sat_o  output  1  last published sample saturated (>=255 edges)
- tach_stall_o  output  1  fan stalled

## Operation
- Synchroniser: two flops sync1 -> sync2, both reset to 0.
- Glitch filter: registered filt (reset 0) and debounce counter dcnt. If sync2 == filt: dcnt <= 0. Else if dcnt == DEBOUNCE_LEN-1: filt <= sync2, dcnt <= 0. Else dcnt <= dcnt+1. Pulses shorter than DEBOUNCE_LEN cycles at sync2 are discarded.
- Edge detect: filt_d registered copy of filt; rise = filt & ~filt_d. Falling edges ignored.
- Edge counter ecnt (9-bit or 8-bit + sticky sat): increments on rise, saturates at 255, sets internal sat flag on any attempted increment past 255.
- Gate timer gcnt (17-bit): counts 0..GATE_DIV, wraps to 0.
- Window close (cycle where gcnt == GATE_DIV): speed_o <= ecnt including a rise in that same cycle (saturated); speed_sat_o <= sat (including that rise); speed_valid_o <= 1 next cycle only; ecnt, sat <= 0.
- Stall: 4-bit zcnt. On window close with result 0: zcnt <= min(zcnt+1, STALL_WINDOWS); tach_stall_o <= 1 when new zcnt == STALL_WINDOWS. On window close with result > 0: zcnt <= 0, tach_stall_o <= 0.
- ena low (synchronous): gcnt, ecnt, sat, dcnt cleared; speed_valid_o = 0; speed_o, speed_sat_o, tach_stall_o, zcnt hold; synchroniser and filt keep tracking. On ena return high, a fresh full window starts at gcnt = 0.

## Timing
- Reset values: speed_o = 0, speed_valid_o = 0, speed_sat_o = 0, tach_stall_o = 0; all internal registers 0.
- tach_in rise stable before edge k (captured in sync1 at k): sync2 at k+1, filt at k+1+DEBOUNCE_LEN, counted in ecnt at edge k+2+DEBOUNCE_LEN.
- First window after reset release starts at gcnt = 0 on first cycle with rst_n = 1 and ena = 1; first speed_valid_o asserted GATE_DIV+1 cycles later, registered (visible the cycle after gcnt == GATE_DIV).
- speed_valid_o exactly one cycle per window, period GATE_DIV+1 cycles while ena high.
- Rise coinciding with window close: counted in the closing window, never the next.
- Reset mid-window: partial count discarded, no valid strobe, outputs forced to reset values.
- Minimum countable tach period: 2*DEBOUNCE_LEN+2 clk cycles; faster input may under-count (accepted).

## Test plan
- Bench parameters GATE_DIV = 99, DEBOUNCE_LEN = 3, STALL_WINDOWS = 3.
- Reset/idle: rst_n low 3 cycles, tach_in = 0 -> all outputs 0; first speed_valid_o 100 cycles after release with speed_o = 0.
- Steady tach: square wave period 20 cycles (10 high/10 low) -> each valid reports speed_o = 5 (±1 on first window due to phase), speed_sat_o = 0, valid spacing exactly 100 cycles.
- Glitch rejection: 2-cycle high pulses every 10 cycles -> speed_o = 0; 4-cycle pulses -> counted.
- Saturation: GATE_DIV = 2999, period 10 (5/5) -> ~300 edges -> speed_o = 255, speed_sat_o = 1.
- Stall: tach held low -> tach_stall_o rises with 3rd valid; then 20-cycle tach wave -> tach_stall_o clears at next valid with speed_o > 0.
- Enable/reset mid-window: drop ena at gcnt ≈ 50 for 10 cycles -> no valid in that period, speed_o holds, next valid 100 cycles after ena returns; rst_n low mid-window -> outputs 0 next edge.

Source files
------------

// File: rtl/fan_tach_counter.sv
// Fan tachometer speed measurement: sync + glitch filter, rising-edge count per gate
// window, saturated 8-bit speed sample with valid strobe, and stall detection.
module fan_tach_counter #(
  parameter int unsigned GATE_DIV      = 99_999,
  parameter int unsigned DEBOUNCE_LEN  = 3,
  parameter int unsigned STALL_WINDOWS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tach_in,
  output logic [7:0] speed_o,
  output logic       speed_valid_o,
  output logic       speed_sat_o,
  output logic       tach_stall_o
);

  localparam int unsigned GATE_W  = 17;
  localparam int unsigned SPEED_W = 8;
  localparam int unsigned ZCNT_W  = 4;
  localparam int unsigned DCNT_W  = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;

  localparam logic [GATE_W-1:0] GATE_MAX   = GATE_W'(GATE_DIV);
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEBOUNCE_LEN - 1);
  localparam logic [ZCNT_W-1:0] STALL_LIM  = ZCNT_W'(STALL_WINDOWS);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               filt_q, filt_d;
  logic               filt_dly_q, filt_dly_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [SPEED_W-1:0] ecnt_q, ecnt_d;
  logic               sat_q, sat_d;
  logic [GATE_W-1:0]  gcnt_q, gcnt_d;
  logic [ZCNT_W-1:0]  zcnt_q, zcnt_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               valid_q, valid_d;
  logic               speed_sat_q, speed_sat_d;
  logic               stall_q, stall_d;

  logic               rise;
  logic               win_close;
  logic [SPEED_W-1:0] ecnt_inc;
  logic               sat_inc;

  // Next-state logic for synchroniser, filter, counters and published sample
  always_comb begin
    sync1_d     = tach_in;
    sync2_d     = sync1_q;
    filt_d      = filt_q;
    dcnt_d      = '0;
    filt_dly_d  = filt_q;
    gcnt_d      = '0;
    ecnt_d      = '0;
    sat_d       = 1'b0;
    valid_d     = 1'b0;
    speed_d     = speed_q;
    speed_sat_d = speed_sat_q;
    zcnt_d      = zcnt_q;
    stall_d     = stall_q;

    // While idle the filter follows the line directly so re-enable sees no stale edge
    if (!ena) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (dcnt_q == DCNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end

    rise      = filt_q & ~filt_dly_q;
    ecnt_inc  = (rise && !(&ecnt_q)) ? ecnt_q + SPEED_W'(1) : ecnt_q;
    sat_inc   = sat_q | (rise & (&ecnt_q));
    win_close = ena && (gcnt_q == GATE_MAX);

    if (ena && !win_close) begin
      gcnt_d = gcnt_q + GATE_W'(1);
      ecnt_d = ecnt_inc;
      sat_d  = sat_inc;
    end

    // Publish the closing window, including a rise landing on the close cycle
    if (win_close) begin
      valid_d     = 1'b1;
      speed_d     = ecnt_inc;
      speed_sat_d = sat_inc;
      if (ecnt_inc == '0) begin
        zcnt_d  = (zcnt_q >= STALL_LIM) ? STALL_LIM : zcnt_q + ZCNT_W'(1);
        stall_d = (zcnt_d == STALL_LIM);
      end else begin
        zcnt_d  = '0;
        stall_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_dly_q  <= 1'b0;
      dcnt_q      <= '0;
      ecnt_q      <= '0;
      sat_q       <= 1'b0;
      gcnt_q      <= '0;
      zcnt_q      <= '0;
      speed_q     <= '0;
      valid_q     <= 1'b0;
      speed_sat_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_dly_q  <= filt_dly_d;
      dcnt_q      <= dcnt_d;
      ecnt_q      <= ecnt_d;
      sat_q       <= sat_d;
      gcnt_q      <= gcnt_d;
      zcnt_q      <= zcnt_d;
      speed_q     <= speed_d;
      valid_q     <= valid_d;
      speed_sat_q <= speed_sat_d;
      stall_q     <= stall_d;
    end
  end

  assign speed_o       = speed_q;
  assign speed_valid_o = valid_q;
  assign speed_sat_o   = speed_sat_q;
  assign tach_stall_o  = stall_q;

endmodule

// File: tb/tb_fan_tach_counter.sv
// Self-checking bench for fan_tach_counter: pattern table plus hand-written corner
// sequences, expected window results queued and compared on each valid strobe.
module tb_fan_tach_counter;

  typedef struct {
    int hi;
    int lo;
    int nwin;
    int tmin;
    int tmax;
    int steady;
    bit chk_stall;
  } phase_t;

  typedef struct {
    int smin;
    int smax;
    bit sat;
    bit chk_stall;
    bit stall;
  } exp_t;

  localparam int WIN = 100;

  logic       clk = 1'b0;
  logic       rst_n, ena, tach_in;
  logic       ena2, tach2;
  logic [7:0] speed_o, speed2;
  logic       speed_valid_o, speed_sat_o, tach_stall_o;
  logic       valid2, sat2, stall2;

  int   n_checks, n_pass, cyc, next_due, cnt2;
  int   ph, ph2, pat_hi, pat_lo;
  bit   saw_valid;
  exp_t sb[$];

  always #5 clk = ~clk;

  fan_tach_counter #(.GATE_DIV(99), .DEBOUNCE_LEN(3), .STALL_WINDOWS(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tach_in(tach_in),
    .speed_o(speed_o), .speed_valid_o(speed_valid_o),
    .speed_sat_o(speed_sat_o), .tach_stall_o(tach_stall_o)
  );

  fan_tach_counter #(.GATE_DIV(2999), .DEBOUNCE_LEN(3), .STALL_WINDOWS(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .tach_in(tach2),
    .speed_o(speed2), .speed_valid_o(valid2),
    .speed_sat_o(sat2), .tach_stall_o(stall2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur, required within budget (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t mk_exp(input int smin, input int smax, input bit chk, input bit stall);
    exp_t e;
    e.smin = smin; e.smax = smax; e.sat = 1'b0; e.chk_stall = chk; e.stall = stall;
    return e;
  endfunction

  task automatic set_pat(input int hi, input int lo);
    pat_hi = hi; pat_lo = lo; ph = 0;
  endtask

  // One clock: sample outputs on the falling edge, score valids, then drive tach inputs
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    saw_valid = speed_valid_o;
    if (speed_valid_o) begin
      if (next_due != 0) check("valid_spacing", cyc, next_due);
      next_due = cyc + WIN;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(speed_valid_o), 0);
      end else begin
        e = sb.pop_front();
        check_rng("speed", 32'(speed_o), e.smin, e.smax);
        check("speed_sat", 32'(speed_sat_o), 32'(e.sat));
        if (e.chk_stall) check("tach_stall", 32'(tach_stall_o), 32'(e.stall));
      end
    end else if (next_due != 0 && cyc == next_due) begin
      check("valid_on_time", 32'(speed_valid_o), 1);
      next_due = 0;
    end
    if (valid2) begin
      cnt2++;
      check("sat_speed", 32'(speed2), 255);
      check("sat_flag", 32'(sat2), 1);
    end
    tach_in = (pat_hi > 0) && (ph < pat_hi);
    ph = (ph + 1 >= pat_hi + pat_lo) ? 0 : ph + 1;
    tach2 = (ph2 < 5);
    ph2 = (ph2 + 1) % 10;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    saw_valid = 1'b0;
    while (!saw_valid && n < budget) begin
      tick();
      n++;
    end
    if (!saw_valid) fail_now("valid_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    phase_t tbl[3];
    int     n;
    tbl[0] = '{hi: 10, lo: 10, nwin: 8, tmin: 4, tmax: 6,  steady: 5,  chk_stall: 1'b1};
    tbl[1] = '{hi: 2,  lo: 8,  nwin: 3, tmin: 0, tmax: 6,  steady: 0,  chk_stall: 1'b0};
    tbl[2] = '{hi: 4,  lo: 6,  nwin: 6, tmin: 8, tmax: 11, steady: 10, chk_stall: 1'b1};

    n_checks = 0; n_pass = 0; cyc = 0; next_due = 0; cnt2 = 0; ph2 = 0;
    rst_n = 1'b0; ena = 1'b1; ena2 = 1'b1; tach_in = 1'b0; tach2 = 1'b0;
    set_pat(0, 10);

    // Reset with tach idle
    repeat (3) tick();
    check("rst_speed", 32'(speed_o), 0);
    check("rst_valid", 32'(speed_valid_o), 0);
    check("rst_sat", 32'(speed_sat_o), 0);
    check("rst_stall", 32'(tach_stall_o), 0);

    // Held-low tach: zero windows, stall on the third
    rst_n = 1'b1;
    next_due = cyc + WIN;
    sb.push_back(mk_exp(0, 0, 1'b1, 1'b0));
    sb.push_back(mk_exp(0, 0, 1'b1, 1'b0));
    sb.push_back(mk_exp(0, 0, 1'b1, 1'b1));
    sb.push_back(mk_exp(0, 0, 1'b1, 1'b1));
    repeat (4) wait_valid(WIN + 50);

    // Pattern table: first window after a change is transitional, then exact
    for (int i = 0; i < 3; i++) begin
      set_pat(tbl[i].hi, tbl[i].lo);
      sb.push_back(mk_exp(tbl[i].tmin, tbl[i].tmax, tbl[i].chk_stall && tbl[i].tmin > 0, 1'b0));
      for (int w = 1; w < tbl[i].nwin; w++)
        sb.push_back(mk_exp(tbl[i].steady, tbl[i].steady, tbl[i].chk_stall, 1'b0));
      repeat (tbl[i].nwin) wait_valid(WIN + 50);
    end

    // Enable dropped mid-window: no strobe, outputs hold, fresh window after return
    repeat (50) tick();
    ena = 1'b0;
    next_due = 0;
    repeat (10) tick();
    check("hold_speed", 32'(speed_o), 10);
    check("hold_sat", 32'(speed_sat_o), 0);
    check("hold_valid", 32'(speed_valid_o), 0);
    ena = 1'b1;
    next_due = cyc + WIN;
    sb.push_back(mk_exp(9, 11, 1'b1, 1'b0));
    wait_valid(WIN + 50);

    // Let the long-window instance publish its saturated sample
    ena = 1'b0;
    next_due = 0;
    n = 0;
    while (cnt2 == 0 && n < 4000) begin
      tick();
      n++;
    end
    check("sat_window_seen", (cnt2 > 0) ? 1 : 0, 1);

    // Reset mid-window: outputs cleared on the next edge, partial window discarded
    ena = 1'b1;
    repeat (50) tick();
    set_pat(0, 10);
    rst_n = 1'b0;
    tick();
    check("mid_rst_speed", 32'(speed_o), 0);
    check("mid_rst_valid", 32'(speed_valid_o), 0);
    check("mid_rst_sat", 32'(speed_sat_o), 0);
    check("mid_rst_stall", 32'(tach_stall_o), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    next_due = cyc + WIN;
    sb.push_back(mk_exp(0, 0, 1'b1, 1'b0));
    wait_valid(WIN + 50);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
